priority_resolver: RTL and testbench
====================================

PRIORITY_RESOLVER -- requirements
Module: priority_resolver

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: RESET  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: IR  in  8  external interrupt request lines IR7..IR0.
REQ-004 SHALL have port: LTIM  in  1  trigger mode; 0 = edge, 1 = level.
REQ-005 SHALL have port: IMR  in  8  interrupt mask; bit i = 1 masks IR i.
REQ-006 SHALL have port: INTA_count  in  2  acknowledge sequence count from control logic; 3 = idle, 0 = INT raised, 1 = first INTA, 2 = second INTA.
REQ-007 SHALL have port: EOI  in  1  end-of-interrupt level from control logic.
REQ-008 SHALL have port: rotate  in  1  automatic-rotation request, qualified by EOI.
REQ-009 SHALL have port: INT_request  out  1  registered request to control logic.
REQ-010 SHALL have port: Interrupt_number  out  3  registered index of the winning request.
REQ-011 SHALL have port: IRR  out  8  interrupt request register.
REQ-012 SHALL have port: ISR  out  8  in-service register.

Function
REQ-013 SHALL register IR into ir_prev every cycle.
REQ-014 Edge mode: SHALL set IRR[i] when IR[i]=1 and ir_prev[i]=0; IRR[i] SHALL then hold until acknowledged.
REQ-015 Level mode: IRR[i] SHALL equal the registered IR[i], except that it clears on acknowledge for one cycle.
REQ-016 Priority order SHALL be circular from base pointer B (0..7): B highest, B+1 next, and so on mod 8.
REQ-017 The candidate SHALL be the highest-priority bit of IRR & ~IMR.
REQ-018 The candidate SHALL be eligible only if it has strictly higher priority than the highest-priority set ISR bit, or if ISR = 0.
REQ-019 INT_request SHALL be 1 in the cycle after an eligible candidate exists and 0 in the cycle after none exists (1-cycle latency).
REQ-020 Interrupt_number SHALL update to the candidate with INT_request, but SHALL be frozen while INTA_count is 1 or 2.
REQ-021 Acknowledge SHALL be detected when INTA_count changes from 0 to 1 (previous-value register). On that edge: ISR[Interrupt_number] set, IRR[Interrupt_number] cleared, same clock.
REQ-022 EOI rising edge (registered previous value) SHALL clear the highest-priority set ISR bit n; it SHALL be a no-op if ISR = 0.
REQ-023 Ack and EOI edge in the same cycle: EOI SHALL select n from ISR before the ack update; both updates SHALL apply.
REQ-024 An ack clear and a new IR edge on the same bit in the same cycle: the clear SHALL take precedence.
REQ-025 IMR changes SHALL affect the candidate on the next cycle; they SHALL NOT alter IRR or ISR.
REQ-026 Requests that are all masked or all zero: INT_request SHALL be 0 and Interrupt_number SHALL hold its last value.

Reset
REQ-027 RESET SHALL clear IRR, ISR, INT_request and Interrupt_number to 0.
REQ-028 RESET SHALL set B=0, load ir_prev with IR (no spurious edge after reset), and load the INTA_count and EOI history registers with 3 and 0 respectively.
REQ-029 RESET SHALL override all simultaneous events, including mid-acknowledge; the sequence SHALL be abandoned.

Configuration
REQ-030 Macro PRIORITY_ROTATE_EN defined: on an EOI edge with rotate=1, B SHALL become (n+1) mod 8, so the cleared level becomes lowest priority. If ISR = 0, B SHALL be unchanged.
REQ-031 Macro PRIORITY_ROTATE_EN undefined: B SHALL be constant 0 (fixed IR0-highest), and the rotate input SHALL be ignored.

Verification
REQ-032 Edge mode, IMR=0, pulse IR3 -> IRR=0x08; INT_request=1 and Interrupt_number=3 one cycle later; INTA_count 0->1 -> ISR=0x08, IRR=0x00.
REQ-033 IR5 and IR2 raised together -> Interrupt_number=2. After ack of IR2, INT_request=0 while ISR=0x04. EOI edge -> ISR=0, then Interrupt_number=5.
REQ-034 IMR=0x10, level IR4 held high -> INT_request stays 0. IMR=0x00 -> INT_request=1 two cycles later.
REQ-035 PRIORITY_ROTATE_EN: ISR=0x08, EOI with rotate=1 -> B=4. IR3 and IR4 pending -> Interrupt_number=4.
REQ-036 RESET asserted while INTA_count=1 and IR1 held high -> all outputs 0 next cycle, and no IRR set from the held IR1 in edge mode.

Source files
------------

// File: rtl/priority_resolver.sv
// priority_resolver: interrupt request/in-service tracking with circular
// priority resolution for an 8-line interrupt controller.
// Optional feature macro: PRIORITY_ROTATE_EN (automatic rotation on EOI).
// Without it the base pointer is fixed at 0 (IR0 highest) and 'rotate' is
// ignored.
module priority_resolver (
    input  logic       clk,
    input  logic       RESET,
    input  logic [7:0] IR,
    input  logic       LTIM,
    input  logic [7:0] IMR,
    input  logic [1:0] INTA_count,
    input  logic       EOI,
    input  logic       rotate,
    output logic       INT_request,
    output logic [2:0] Interrupt_number,
    output logic [7:0] IRR,
    output logic [7:0] ISR
);

    // Returns {found, index} of the highest-priority set bit of v, where
    // priority runs circularly from base b (b highest, b+1 next, ...).
    function automatic logic [3:0] pick_first(input logic [7:0] v, input logic [2:0] b);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = b + k[2:0];
            if (v[idx]) begin
                r = {1'b1, idx};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [7:0] ir_prev_q;
    logic [7:0] imr_q;
    logic [1:0] inta_prev_q;
    logic       eoi_prev_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic       int_req_q, int_req_d;
    logic [2:0] num_q, num_d;
    logic [2:0] base_s;

    logic       ack_s;
    logic       eoi_edge_s;
    logic [3:0] cand_s;
    logic [3:0] isr_top_s;
    logic [2:0] cand_rank_s;
    logic [2:0] isr_rank_s;
    logic       eligible_s;
    logic [7:0] ack_mask_s;
    logic [7:0] eoi_mask_s;

`ifdef PRIORITY_ROTATE_EN
    logic [2:0] base_q, base_d;

    assign base_s = base_q;

    // Rotation: the level just cleared by EOI becomes lowest priority.
    always_comb begin
        base_d = base_q;
        if (eoi_edge_s && rotate && isr_top_s[3]) begin
            base_d = isr_top_s[2:0] + 3'd1;
        end else begin
            base_d = base_q;
        end
    end

    // Base pointer register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            base_q <= 3'd0;
        end else begin
            base_q <= base_d;
        end
    end
`else
    logic unused_rotate_s;

    assign base_s          = 3'd0;
    assign unused_rotate_s = rotate;
`endif

    // Event detection, priority resolution and next-state computation.
    always_comb begin
        ack_s       = (inta_prev_q == 2'd0) && (INTA_count == 2'd1);
        eoi_edge_s  = EOI && !eoi_prev_q;
        cand_s      = pick_first(irr_q & ~imr_q, base_s);
        isr_top_s   = pick_first(isr_q, base_s);
        cand_rank_s = cand_s[2:0] - base_s;
        isr_rank_s  = isr_top_s[2:0] - base_s;
        eligible_s  = cand_s[3] && (!isr_top_s[3] || (cand_rank_s < isr_rank_s));

        ack_mask_s  = ack_s ? (8'd1 << num_q) : 8'd0;
        // EOI picks its victim from ISR as it stands before any ack update.
        eoi_mask_s  = (eoi_edge_s && isr_top_s[3]) ? (8'd1 << isr_top_s[2:0]) : 8'd0;

        // Ack clear is applied last so it wins over a same-cycle new edge.
        if (LTIM) begin
            irr_d = IR & ~ack_mask_s;
        end else begin
            irr_d = (irr_q | (IR & ~ir_prev_q)) & ~ack_mask_s;
        end

        isr_d     = (isr_q & ~eoi_mask_s) | ack_mask_s;
        int_req_d = eligible_s;

        // Number is frozen during the acknowledge sequence so the ack uses it.
        if (eligible_s && (INTA_count != 2'd1) && (INTA_count != 2'd2)) begin
            num_d = cand_s[2:0];
        end else begin
            num_d = num_q;
        end
    end

    // State registers; reset abandons any acknowledge in progress.
    always_ff @(posedge clk) begin
        if (RESET) begin
            ir_prev_q   <= IR;
            imr_q       <= IMR;
            inta_prev_q <= 2'd3;
            eoi_prev_q  <= 1'b0;
            irr_q       <= 8'd0;
            isr_q       <= 8'd0;
            int_req_q   <= 1'b0;
            num_q       <= 3'd0;
        end else begin
            ir_prev_q   <= IR;
            imr_q       <= IMR;
            inta_prev_q <= INTA_count;
            eoi_prev_q  <= EOI;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            int_req_q   <= int_req_d;
            num_q       <= num_d;
        end
    end

    assign INT_request      = int_req_q;
    assign Interrupt_number = num_q;
    assign IRR              = irr_q;
    assign ISR              = isr_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Directed self-checking bench for priority_resolver. Expected output words
// {INT_request, Interrupt_number, IRR, ISR} are queued when stimulus is
// driven and popped after the following clock edge.
module tb_priority_resolver;

    logic       clk;
    logic       RESET;
    logic [7:0] IR;
    logic       LTIM;
    logic [7:0] IMR;
    logic [1:0] INTA_count;
    logic       EOI;
    logic       rotate;
    logic       INT_request;
    logic [2:0] Interrupt_number;
    logic [7:0] IRR;
    logic [7:0] ISR;

    typedef struct {
        string       tag;
        logic [19:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;

`ifdef PRIORITY_ROTATE_EN
    localparam logic [2:0] ROT_NUM = 3'd4;
`else
    localparam logic [2:0] ROT_NUM = 3'd3;
`endif

    priority_resolver dut (
        .clk              (clk),
        .RESET            (RESET),
        .IR               (IR),
        .LTIM             (LTIM),
        .IMR              (IMR),
        .INTA_count       (INTA_count),
        .EOI              (EOI),
        .rotate           (rotate),
        .INT_request      (INT_request),
        .Interrupt_number (Interrupt_number),
        .IRR              (IRR),
        .ISR              (ISR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] e(input logic i, input logic [2:0] n,
                                      input logic [7:0] irr, input logic [7:0] isr);
        return {i, n, irr, isr};
    endfunction

    // Queue the expectation, clock once, then pop and compare.
    task automatic step(input string tag, input logic [19:0] val);
        exp_t ex;
        exp_t got;
        logic [19:0] obs;
        ex.tag = tag;
        ex.val = val;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        obs = {INT_request, Interrupt_number, IRR, ISR};
        got = exp_q.pop_front();
        tests_run++;
        assert (obs === got.val) else begin
            tests_failed++;
            $error("FAIL %s: observed int=%b num=%0d irr=%h isr=%h expected int=%b num=%0d irr=%h isr=%h",
                   got.tag, obs[19], obs[18:16], obs[15:8], obs[7:0],
                   got.val[19], got.val[18:16], got.val[15:8], got.val[7:0]);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        RESET = 1'b1; IR = 8'h00; LTIM = 1'b0; IMR = 8'h00;
        INTA_count = 2'd3; EOI = 1'b0; rotate = 1'b0;
        @(posedge clk); #1;
        step("reset", e(1'b0, 3'd0, 8'h00, 8'h00));
        RESET = 1'b0;
        step("idle", e(1'b0, 3'd0, 8'h00, 8'h00));

        // Single edge request on IR3, acknowledge, EOI
        IR = 8'h08;       step("ir3_irr",    e(1'b0, 3'd0, 8'h08, 8'h00));
        IR = 8'h00;       step("ir3_int",    e(1'b1, 3'd3, 8'h08, 8'h00));
        INTA_count = 2'd0; step("ir3_int0",  e(1'b1, 3'd3, 8'h08, 8'h00));
        INTA_count = 2'd1; step("ir3_ack",   e(1'b1, 3'd3, 8'h00, 8'h08));
        INTA_count = 2'd2; step("ir3_inta2", e(1'b0, 3'd3, 8'h00, 8'h08));
        INTA_count = 2'd3; step("ir3_idle",  e(1'b0, 3'd3, 8'h00, 8'h08));
        EOI = 1'b1;        step("ir3_eoi",   e(1'b0, 3'd3, 8'h00, 8'h00));
        EOI = 1'b0;        step("ir3_done",  e(1'b0, 3'd3, 8'h00, 8'h00));

        // IR5 + IR2 together: IR2 wins, IR5 blocked while IR2 in service
        IR = 8'h24;        step("p_irr",     e(1'b0, 3'd3, 8'h24, 8'h00));
        IR = 8'h00;        step("p_win2",    e(1'b1, 3'd2, 8'h24, 8'h00));
        INTA_count = 2'd0; step("p_int0",    e(1'b1, 3'd2, 8'h24, 8'h00));
        INTA_count = 2'd1; step("p_ack2",    e(1'b1, 3'd2, 8'h20, 8'h04));
        INTA_count = 2'd2; step("p_block5",  e(1'b0, 3'd2, 8'h20, 8'h04));
        INTA_count = 2'd3; step("p_block5b", e(1'b0, 3'd2, 8'h20, 8'h04));
        EOI = 1'b1;        step("p_eoi",     e(1'b0, 3'd2, 8'h20, 8'h00));
        EOI = 1'b0;        step("p_win5",    e(1'b1, 3'd5, 8'h20, 8'h00));
        INTA_count = 2'd0; step("p5_int0",   e(1'b1, 3'd5, 8'h20, 8'h00));
        INTA_count = 2'd1; step("p5_ack",    e(1'b1, 3'd5, 8'h00, 8'h20));
        INTA_count = 2'd3; step("p5_idle",   e(1'b0, 3'd5, 8'h00, 8'h20));
        EOI = 1'b1;        step("p5_eoi",    e(1'b0, 3'd5, 8'h00, 8'h00));
        EOI = 1'b0;

        // Ack clear beats a same-cycle new edge on the same bit
        IR = 8'h02;        step("c_irr",     e(1'b0, 3'd5, 8'h02, 8'h00));
        IR = 8'h00;        step("c_int",     e(1'b1, 3'd1, 8'h02, 8'h00));
        INTA_count = 2'd0; step("c_int0",    e(1'b1, 3'd1, 8'h02, 8'h00));
        INTA_count = 2'd1; IR = 8'h02;
                           step("c_clear",   e(1'b1, 3'd1, 8'h00, 8'h02));
        INTA_count = 2'd3; IR = 8'h00;
                           step("c_idle",    e(1'b0, 3'd1, 8'h00, 8'h02));
        EOI = 1'b1;        step("c_eoi",     e(1'b0, 3'd1, 8'h00, 8'h00));
        EOI = 1'b0;        step("c_eoi0",    e(1'b0, 3'd1, 8'h00, 8'h00));

        // Level mode, masked IR4, then unmask: request two cycles later
        LTIM = 1'b1; IMR = 8'h10; IR = 8'h10;
                           step("m_irr",     e(1'b0, 3'd1, 8'h10, 8'h00));
                           step("m_masked",  e(1'b0, 3'd1, 8'h10, 8'h00));
        IMR = 8'h00;       step("m_unmask1", e(1'b0, 3'd1, 8'h10, 8'h00));
                           step("m_unmask2", e(1'b1, 3'd4, 8'h10, 8'h00));
        INTA_count = 2'd0; step("l_int0",    e(1'b1, 3'd4, 8'h10, 8'h00));
        INTA_count = 2'd1; step("l_ack",     e(1'b1, 3'd4, 8'h00, 8'h10));
        INTA_count = 2'd2; step("l_reload",  e(1'b0, 3'd4, 8'h10, 8'h10));
        INTA_count = 2'd3; step("l_equal",   e(1'b0, 3'd4, 8'h10, 8'h10));
        IR = 8'h00; EOI = 1'b1;
                           step("l_eoi",     e(1'b0, 3'd4, 8'h00, 8'h00));
        EOI = 1'b0; LTIM = 1'b0;
                           step("l_done",    e(1'b0, 3'd4, 8'h00, 8'h00));

        // All masked: no request, number holds; partial mask picks IR7
        IMR = 8'hFF; IR = 8'h81;
                           step("a_irr",     e(1'b0, 3'd4, 8'h81, 8'h00));
        IR = 8'h00;        step("a_mask1",   e(1'b0, 3'd4, 8'h81, 8'h00));
                           step("a_mask2",   e(1'b0, 3'd4, 8'h81, 8'h00));
        IMR = 8'h01;       step("a_part1",   e(1'b0, 3'd4, 8'h81, 8'h00));
                           step("a_part2",   e(1'b1, 3'd7, 8'h81, 8'h00));

        // Reset mid-acknowledge with IR1 held high
        INTA_count = 2'd0; step("r_int0",    e(1'b1, 3'd7, 8'h81, 8'h00));
        INTA_count = 2'd1; step("r_ack",     e(1'b1, 3'd7, 8'h01, 8'h80));
        RESET = 1'b1; IR = 8'h02;
                           step("r_reset",   e(1'b0, 3'd0, 8'h00, 8'h00));
        RESET = 1'b0;      step("r_noedge",  e(1'b0, 3'd0, 8'h00, 8'h00));
        INTA_count = 2'd3; IR = 8'h00; IMR = 8'h00;
                           step("r_idle",    e(1'b0, 3'd0, 8'h00, 8'h00));

        // EOI with rotate=1 after IR3 service, then IR3+IR4 pending
        IR = 8'h08;        step("o_irr",     e(1'b0, 3'd0, 8'h08, 8'h00));
        IR = 8'h00;        step("o_int",     e(1'b1, 3'd3, 8'h08, 8'h00));
        INTA_count = 2'd0; step("o_int0",    e(1'b1, 3'd3, 8'h08, 8'h00));
        INTA_count = 2'd1; step("o_ack",     e(1'b1, 3'd3, 8'h00, 8'h08));
        INTA_count = 2'd3; step("o_idle",    e(1'b0, 3'd3, 8'h00, 8'h08));
        EOI = 1'b1; rotate = 1'b1;
                           step("o_eoi",     e(1'b0, 3'd3, 8'h00, 8'h00));
        EOI = 1'b0; rotate = 1'b0; IR = 8'h18;
                           step("o_irr2",    e(1'b0, 3'd3, 8'h18, 8'h00));
        IR = 8'h00;        step("o_rotwin",  e(1'b1, ROT_NUM, 8'h18, 8'h00));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
